// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder sequencing controller.
package viterbi_pkg;

  typedef enum logic [2:0] {StIdle, StFill, StAcs, StTrace, StEmit} state_e;

  typedef logic [1:0] acs_phase_t;

  localparam acs_phase_t PH_INIT0  = 2'd0;
  localparam acs_phase_t PH_INIT1  = 2'd1;
  localparam acs_phase_t PH_STEADY = 2'd2;

  localparam int unsigned WIN_DEPTH_DEF = 15;

  localparam logic [2:0] CL_MIN = 3'd3;
  localparam logic [2:0] CL_MAX = 3'd6;

endpackage

// File: rtl/col_wrap_ctr.sv
// Survivor-memory column counter: counts up or down modulo Depth, with parallel load.
module col_wrap_ctr #(
  parameter int unsigned Depth = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o
);

  localparam logic [3:0] MaxCol = 4'(Depth - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = (cnt_q == MaxCol) ? 4'd0 : cnt_q + 4'd1;
    end else if (dec_i) begin
      cnt_d = (cnt_q == 4'd0) ? MaxCol : cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/viterbi_sched.sv
// Viterbi decoder sequencer: symbol intake, ACS strobes, sliding-window traceback
// and decoded-bit hand-off, including end-of-frame flush.
module viterbi_sched
  import viterbi_pkg::*;
#(
  parameter int unsigned WIN_DEPTH = WIN_DEPTH_DEF,
  parameter int unsigned FLEN_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cfg_k,
  input  logic [FLEN_W-1:0] frame_len,
  output logic [2:0]        k_q,
  input  logic              sym_valid,
  input  logic [1:0]        sym_data,
  output logic              sym_ready,
  output logic              acs_en,
  output logic [1:0]        acs_phase,
  output logic [1:0]        acs_sym,
  output logic [3:0]        wr_col,
  output logic              tb_en,
  output logic [3:0]        tb_col,
  input  logic              tb_bit,
  output logic              out_valid,
  output logic              out_bit,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_e state_q, state_d;

  logic [FLEN_W-1:0] flen_q, sym_cnt_q, out_cnt_q;
  logic [FLEN_W-1:0] sym_cnt_inc, out_cnt_inc;
  logic [3:0]        tb_left_q;
  logic [2:0]        cfg_k_q;
  acs_phase_t        acs_phase_q;
  logic [1:0]        acs_sym_q;
  logic              out_bit_q, done_q, cfg_err_q;

  logic cfg_ok, acs_to_trace, trace_last, last_bit, flushing;
  logic wr_load, wr_inc, tb_load;

  assign sym_cnt_inc  = sym_cnt_q + FLEN_W'(1);
  assign out_cnt_inc  = out_cnt_q + FLEN_W'(1);
  assign cfg_ok       = (cfg_k >= CL_MIN) && (cfg_k <= CL_MAX) && (frame_len != '0);
  assign acs_to_trace = ((sym_cnt_inc - out_cnt_q) == FLEN_W'(WIN_DEPTH)) ||
                        (sym_cnt_inc == flen_q);
  assign trace_last   = (tb_left_q == 4'd1);
  assign last_bit     = (out_cnt_inc == flen_q);
  assign flushing     = (sym_cnt_q == flen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && cfg_ok) state_d = StFill;
      StFill:  if (sym_valid) state_d = StAcs;
      StAcs:   state_d = acs_to_trace ? StTrace : StFill;
      StTrace: if (trace_last) state_d = StEmit;
      StEmit: begin
        if (out_ready) begin
          if (last_bit) begin
            state_d = StIdle;
          end else if (flushing) begin
            state_d = StTrace;
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sym_ready = (state_q == StFill);
    acs_en    = (state_q == StAcs);
    tb_en     = (state_q == StTrace);
    out_valid = (state_q == StEmit);
    busy      = (state_q != StIdle);
  end

  // Traceback depth is loaded on every entry to TRACE so it shrinks by one per flushed bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flen_q      <= '0;
      sym_cnt_q   <= '0;
      out_cnt_q   <= '0;
      tb_left_q   <= 4'd0;
      cfg_k_q     <= 3'd0;
      acs_phase_q <= PH_INIT0;
      acs_sym_q   <= 2'd0;
      out_bit_q   <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_ok) begin
              cfg_k_q   <= cfg_k;
              flen_q    <= frame_len;
              sym_cnt_q <= '0;
              out_cnt_q <= '0;
              cfg_err_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StFill: begin
          if (sym_valid) begin
            acs_sym_q   <= sym_data;
            acs_phase_q <= (sym_cnt_q == '0)          ? PH_INIT0 :
                           (sym_cnt_q == FLEN_W'(1))  ? PH_INIT1 : PH_STEADY;
          end
        end
        StAcs: begin
          sym_cnt_q <= sym_cnt_inc;
          tb_left_q <= 4'(sym_cnt_inc - out_cnt_q);
        end
        StTrace: begin
          tb_left_q <= tb_left_q - 4'd1;
          if (trace_last) out_bit_q <= tb_bit;
        end
        StEmit: begin
          if (out_ready) begin
            out_cnt_q <= out_cnt_inc;
            done_q    <= last_bit;
            tb_left_q <= 4'(sym_cnt_q - out_cnt_inc);
          end
        end
        default: ;
      endcase
    end
  end

  // wr_col already holds the previous symbol's column, so it steps on every accept but the first.
  assign wr_load = (state_q == StIdle) && start && cfg_ok;
  assign wr_inc  = (state_q == StFill) && sym_valid && (sym_cnt_q != '0);
  assign tb_load = (state_d == StTrace) && (state_q != StTrace);

  col_wrap_ctr #(
    .Depth (WIN_DEPTH)
  ) u_wr_col (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wr_load),
    .load_val_i (4'd0),
    .inc_i      (wr_inc),
    .dec_i      (1'b0),
    .cnt_o      (wr_col)
  );

  col_wrap_ctr #(
    .Depth (WIN_DEPTH)
  ) u_tb_col (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tb_load),
    .load_val_i (wr_col),
    .inc_i      (1'b0),
    .dec_i      (state_q == StTrace),
    .cnt_o      (tb_col)
  );

  assign k_q       = cfg_k_q;
  assign acs_phase = acs_phase_q;
  assign acs_sym   = acs_sym_q;
  assign out_bit   = out_bit_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
